// File: rtl/three_and_seq_pkg.sv
// Shared definitions for the three-input AND gate sequencer.
// Optional checking logic is controlled by the THREE_AND_SEQ_CHECK_EN macro.
package three_and_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] VEC_LAST = 3'b111;
    localparam int         DWELL_W  = 4;
    localparam logic [3:0] ERR_MAX  = 4'd15;

    // Increment that sticks at the top of the 4-bit error range.
    function automatic logic [3:0] sat_inc(input logic [3:0] val);
        return (val == ERR_MAX) ? val : val + 4'd1;
    endfunction

endpackage

// File: rtl/three_and_seq_timer.sv
// Dwell countdown: load a start value, count down to zero, then hold at zero.
// 'expired' is high whenever the count reads zero.
import three_and_seq_pkg::*;

module three_and_seq_timer (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] value,
    output logic               expired
);

    logic [DWELL_W-1:0] r_count;

    // Load has priority; otherwise count down and stop at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - DWELL_W'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule

// File: rtl/three_and_seq.sv
// Sweeps all eight input vectors of an external 3-input AND gate, holding each
// vector for DWELL cycles and sampling the gate output once per vector.
// Define THREE_AND_SEQ_CHECK_EN to compile in the compare / err_cnt / pass logic;
// without it err_cnt and pass read 0 and outD is ignored.
// Handshake: start is a level request sampled only in IDLE; busy covers DRIVE
// and SAMPLE; done is a single-cycle pulse in DONE.
import three_and_seq_pkg::*;

module three_and_seq #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       outD,
    output logic       inA,
    output logic       inB,
    output logic       inC,
    output logic [2:0] vec,
    output logic       busy,
    output logic       done,
    output logic [3:0] err_cnt,
    output logic       pass,
    output logic [1:0] dbg_state
);

    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_vec;
    logic [2:0] w_vec_nxt;
    logic [2:0] r_gate;
    logic       w_load;
    logic       w_expired;

    three_and_seq_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_load),
        .value   (DWELL_LOAD),
        .expired (w_expired)
    );

    // State and vector index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_vec   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
        end
    end

    // Next-state, next-vector and dwell reload decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = DRIVE;
                    w_vec_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            DRIVE: begin
                if (w_expired) begin
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                // Vector 7 is terminal; the index never wraps inside a sweep.
                if (r_vec == VEC_LAST) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = DRIVE;
                    w_vec_nxt   = r_vec + 3'd1;
                    w_load      = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Gate inputs registered from the next vector so they line up with DRIVE/SAMPLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate <= '0;
        end else if ((w_state_nxt == DRIVE) || (w_state_nxt == SAMPLE)) begin
            r_gate <= w_vec_nxt;
        end else begin
            r_gate <= '0;
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy      = (r_state == DRIVE) || (r_state == SAMPLE);
        done      = (r_state == DONE);
        inA       = r_gate[2];
        inB       = r_gate[1];
        inC       = r_gate[0];
        vec       = r_vec;
        dbg_state = r_state;
    end

`ifdef THREE_AND_SEQ_CHECK_EN
    logic [3:0] r_err_cnt;
    logic       r_pass;
    logic       w_mismatch;

    assign w_mismatch = (r_state == SAMPLE) && (outD != (&r_vec));

    // Error count and sticky pass flag; both cleared only by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
            r_pass    <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_err_cnt <= '0;
            r_pass    <= 1'b0;
        end else begin
            if (w_mismatch) begin
                r_err_cnt <= sat_inc(r_err_cnt);
            end
            if (r_state == DONE) begin
                r_pass <= (r_err_cnt == '0);
            end
        end
    end

    assign err_cnt = r_err_cnt;
    assign pass    = r_pass;
`else
    logic w_unused_outd;
    assign w_unused_outd = outD;
    assign err_cnt       = '0;
    assign pass          = 1'b0;
`endif

endmodule

// File: tb/tb_three_and_seq.sv
// Directed bench for three_and_seq (DWELL=4): good gate, stuck-at gates,
// start noise while busy, async reset mid-sweep, held start and random outD.
module tb_three_and_seq;
    import three_and_seq_pkg::*;

    localparam int DWELL    = 4;
    localparam int PER      = DWELL + 1;
    localparam int BUSY_CYC = 8 * PER;
    localparam int PERIOD   = BUSY_CYC + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       outD;
    logic       inA, inB, inC;
    logic [2:0] vec;
    logic       busy, done, pass;
    logic [3:0] err_cnt;
    logic [1:0] dbg_state;

    int   gate_mode;
    logic rnd_bit;
    int   checks = 0;
    int   errors = 0;

    three_and_seq #(.DWELL(DWELL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .outD      (outD),
        .inA       (inA),
        .inB       (inB),
        .inC       (inC),
        .vec       (vec),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .pass      (pass),
        .dbg_state (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // Gate model: 0 = real AND, 1 = stuck at 1, 2 = stuck at 0, else random.
    function automatic logic gate_out(input int mode, input logic [2:0] abc, input logic rnd);
        case (mode)
            0:       return &abc;
            1:       return 1'b1;
            2:       return 1'b0;
            default: return rnd;
        endcase
    endfunction

    assign outD = gate_out(gate_mode, {inA, inB, inC}, rnd_bit);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One or more sweeps from a start request; hand_err < 0 uses the bench model.
    task automatic sweep(input string tag, input int mode, input bit noise,
                         input int n_sweeps, input int hand_err);
        int         exp_err;
        int         exp_final;
        logic       exp_pass;
        int         n_cyc;
        int         p;
        int         bad_busy, bad_done, bad_abc, bad_vec, idle_bad;
        logic [2:0] exp_abc;
        logic       exp_busy, exp_done;
        logic [3:0] err_hold;
        logic       pass_hold;
        gate_mode = mode;
        exp_err   = 0;
        bad_busy  = 0;
        bad_done  = 0;
        bad_abc   = 0;
        bad_vec   = 0;
        idle_bad  = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (n_sweeps == 1) start = 1'b0;
        n_cyc = n_sweeps * PERIOD - 1;
        for (int c = 1; c <= n_cyc; c++) begin
            p        = (c - 1) % PERIOD;
            exp_busy = (p < BUSY_CYC);
            exp_done = (p == BUSY_CYC);
            exp_abc  = exp_busy ? 3'(p / PER) : 3'b000;
            if (busy !== exp_busy) bad_busy++;
            if (done !== exp_done) bad_done++;
            if ({inA, inB, inC} !== exp_abc) bad_abc++;
            if (vec !== (exp_busy ? exp_abc : 3'b111)) bad_vec++;
            rnd_bit = 1'($urandom_range(0, 1));
            if (p == 0) exp_err = 0;
            if (exp_busy && (p % PER == DWELL) &&
                (gate_out(mode, exp_abc, rnd_bit) != (exp_abc == 3'b111)) && exp_err < 15)
                exp_err++;
            if (noise) start = (p >= 1 && p < BUSY_CYC - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c == n_cyc) start = 1'b0;
            @(negedge clk);
        end
        check({tag, "_busy"}, bad_busy, 0);
        check({tag, "_done"}, bad_done, 0);
        check({tag, "_abc"}, bad_abc, 0);
        check({tag, "_vec"}, bad_vec, 0);
`ifdef THREE_AND_SEQ_CHECK_EN
        exp_final = (hand_err >= 0) ? hand_err : exp_err;
        exp_pass  = (exp_final == 0);
`else
        exp_final = 0;
        exp_pass  = 1'b0;
        if (hand_err < -1) exp_final = exp_err;
`endif
        check({tag, "_err_cnt"}, err_cnt, exp_final);
        check({tag, "_pass"}, pass, exp_pass);
        err_hold  = err_cnt;
        pass_hold = pass;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b0 || done !== 1'b0 || err_cnt !== 4'(exp_final) || pass !== exp_pass)
                idle_bad++;
            @(negedge clk);
        end
        check({tag, "_idle_hold"}, idle_bad, 0);
        check({tag, "_err_stable"}, {err_cnt, pass}, {err_hold, pass_hold});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wait_cyc;
        rst_n     = 1'b0;
        start     = 1'b0;
        gate_mode = 0;
        rnd_bit   = 1'b0;
        #1;
        check("reset", {dbg_state, vec, busy, done, inA, inB, inC, err_cnt, pass}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {dbg_state, busy, done}, {IDLE, 2'b00});

        sweep("good",    0, 1'b0, 1, 0);
        sweep("stuck1",  1, 1'b0, 1, 7);
        sweep("stuck0",  2, 1'b0, 1, 1);
        sweep("noise",   0, 1'b1, 1, 0);

        // Reset during vector 3 with a stuck-at-1 gate so err_cnt is nonzero.
        gate_mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc = 0;
        while (!(vec == 3'd3 && busy) && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("rst_reach_vec3", {busy, vec}, {1'b1, 3'd3});
`ifdef THREE_AND_SEQ_CHECK_EN
        check("rst_pre_err", err_cnt, 3);
`else
        check("rst_pre_err", err_cnt, 0);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", {dbg_state, vec, busy, done, inA, inB, inC, err_cnt, pass}, 0);
        @(negedge clk);
        check("rst_held", {dbg_state, vec, busy, done, inA, inB, inC, err_cnt, pass}, 0);
        rst_n = 1'b1;

        sweep("after_rst", 0, 1'b0, 1, 0);
        sweep("held",      0, 1'b0, 2, 0);
        sweep("random",    3, 1'b0, 1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/three_and_seq.md
THREE_AND_SEQ -- requirements
Module: three_and_seq

Interface
REQ-001 Parameter: DWELL, 4, number of cycles each input vector is held before the output is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes occur on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request one full 8-vector sweep; sampled only in IDLE.
REQ-005 outD  input  1  output of the 3-input AND gate under control.
REQ-006 inA  output  1  gate input A, equal to vec[2].
REQ-007 inB  output  1  gate input B, equal to vec[1].
REQ-008 inC  output  1  gate input C, equal to vec[0].
REQ-009 vec  output  3  current vector index 0..7.
REQ-010 busy  output  1  high in DRIVE and SAMPLE.
REQ-011 done  output  1  one-cycle pulse in the DONE state.
REQ-012 err_cnt  output  4  number of mismatching vectors in the current or last sweep.
REQ-013 pass  output  1  sticky result of the last completed sweep.

Function
REQ-014 The FSM SHALL have the states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 In IDLE with start=1, the block SHALL clear vec and err_cnt, clear pass, load the dwell counter with DWELL-1 and go to DRIVE.
REQ-016 In DRIVE, the block SHALL decrement the dwell counter each cycle and go to SAMPLE in the cycle after the counter reads 0, so each vector is driven for DWELL cycles.
REQ-017 In SAMPLE, the block SHALL compare outD with &vec and increment err_cnt on mismatch, saturating at 15.
REQ-018 From SAMPLE, if vec==7 the FSM SHALL go to DONE; otherwise it SHALL increment vec, reload the dwell counter and return to DRIVE.
REQ-019 In DONE, the block SHALL assert done for one cycle, set pass=(err_cnt==0) and go to IDLE.
REQ-020 inA, inB and inC SHALL be registered and SHALL follow vec in DRIVE and SAMPLE; they SHALL be 0 in IDLE and DONE.
REQ-021 Latency: with start accepted at edge k, DRIVE SHALL begin at k+1 and busy SHALL stay high for 8*(DWELL+1) cycles.
REQ-022 done SHALL be high in cycle k+1+8*(DWELL+1).
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 With start held high, one IDLE cycle SHALL separate done and the next DRIVE.
REQ-025 vec SHALL NOT wrap within a sweep: 7 is terminal.
REQ-026 err_cnt and pass SHALL hold their values until the next accepted start.

Reset
REQ-027 While rst_n=0, the block SHALL force state=IDLE, vec=0, the dwell counter to 0, inA=inB=inC=0, busy=0, done=0, err_cnt=0 and pass=0, immediately and without waiting for clk.
REQ-028 A reset mid-sweep SHALL abandon the sweep; the next start SHALL restart from vec=0.

Configuration
REQ-029 When THREE_AND_SEQ_CHECK_EN is defined, the comparison, err_cnt and pass logic SHALL be compiled in as specified above.
REQ-030 When THREE_AND_SEQ_CHECK_EN is undefined, err_cnt SHALL be tied to 0, pass SHALL be tied to 0 and outD SHALL be unused; sequencing and timing SHALL be unchanged.

Structure
REQ-031 A package three_and_seq_pkg SHALL hold the state enum (IDLE/DRIVE/SAMPLE/DONE), VEC_LAST=3'b111 and DWELL_W=4.
REQ-032 The dwell countdown SHALL be one sub-module, three_and_seq_timer, with ports clk, rst_n, load, value[3:0] and expired.
REQ-033 The gate itself SHALL be external; three_and_seq SHALL only drive and observe it.

Verification
REQ-034 Reset, correct gate, DWELL=4, start pulse at edge k -> busy high for 40 cycles, done at k+41, err_cnt=0, pass=1.
REQ-035 outD stuck at 1 -> err_cnt=7, pass=0.
REQ-036 outD stuck at 0 -> err_cnt=1 (vec 7 only), pass=0.
REQ-037 rst_n low during vec=3 -> all outputs 0 asynchronously; a subsequent start produces the sweep 0..7 from the beginning.
REQ-038 start pulses while busy produce no effect; start held high produces back-to-back sweeps with an inA/inB/inC sequence of 000..111.
REQ-039 THREE_AND_SEQ_CHECK_EN undefined, outD toggled randomly -> err_cnt=0, pass=0, done timing identical to REQ-034.
